doorlock_ctrl: RTL and testbench
================================

DOORLOCK_CTRL -- requirements
Module: doorlock_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 6, number of digits per code.
REQ-002 SHALL have parameter CHECK_LAT, default 2, cycles from the last forwarded digit to a valid corr_i.
REQ-003 SHALL have parameter OPEN_CYCLES, default 1000, unlock hold time.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 5000, inactivity limit while entering a code.
REQ-005 SHALL have parameter MAX_FAIL, default 3, wrong codes allowed before lockout.
REQ-006 SHALL have parameter LOCKOUT_CYCLES, default 10000, lockout duration.
REQ-007 SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port key_i, input, 4 bits, key code: 0x0-0x9 digit, 0xA '*' (abort), 0xB '#' (set); 0xC-0xF are ignored.
REQ-010 SHALL have port key_vld_i, input, 1 bit, one-cycle strobe qualifying key_i.
REQ-011 SHALL have port corr_i, input, 1 bit, code-match result from the passcode store.
REQ-012 SHALL have port number_o, output, 4 bits, forwarded digit to the passcode store.
REQ-013 SHALL have port num_vld_o, output, 1 bit, one-cycle pulse qualifying number_o.
REQ-014 SHALL have port state_o, output, 2 bits, lock state to the passcode store: IDLE=00, ENT_CODE=01, OPEN=11, SET=10.
REQ-015 SHALL have port open_o, output, 1 bit, door unlock drive.
REQ-016 SHALL have port alarm_o, output, 1 bit, high during lockout.

Function
REQ-017 SHALL use internal states IDLE, ENT_CODE, CHECK, OPEN, SET and LOCKOUT; state_o reports CHECK as ENT_CODE and LOCKOUT as IDLE.
REQ-018 SHALL register all outputs; a digit strobe at cycle N gives num_vld_o=1 and number_o=digit at N+1, with state_o already showing the new state at N+1.
REQ-019 SHALL forward digits only in ENT_CODE and SET; it SHALL move IDLE->ENT_CODE on a digit, forward that digit, and set digit_cnt=1.
REQ-020 SHALL, on the CODE_LEN-th digit in ENT_CODE, enter CHECK for exactly CHECK_LAT cycles and sample corr_i on the last CHECK cycle.
REQ-021 SHALL go CHECK->OPEN when corr_i=1 and clear fail_cnt.
REQ-022 SHALL go CHECK->IDLE when corr_i=0 and increment fail_cnt; when fail_cnt reaches MAX_FAIL it SHALL go to LOCKOUT instead.
REQ-023 SHALL hold open_o=1 for exactly OPEN_CYCLES cycles in OPEN, then go to IDLE; '#' in OPEN SHALL go to SET with digit_cnt=0 and open_o=0.
REQ-024 SHALL, in SET, forward CODE_LEN digits, then go to IDLE on the cycle after the last num_vld_o pulse.
REQ-025 SHALL, on '*' in ENT_CODE or SET, go to IDLE, clear digit_cnt, and leave fail_cnt unchanged.
REQ-026 SHALL restart the inactivity timer on each accepted key in ENT_CODE or SET; on reaching TIMEOUT_CYCLES it SHALL go to IDLE and leave fail_cnt unchanged.
REQ-027 SHALL hold alarm_o=1 in LOCKOUT for LOCKOUT_CYCLES, ignore all keys, then go to IDLE and clear fail_cnt.
REQ-028 SHALL ignore key_vld_i in CHECK and LOCKOUT, and ignore '*' and '#' in IDLE.
REQ-029 SHALL let a digit arriving on the same cycle a timeout expires lose: the timeout wins and the digit is dropped.
REQ-030 SHALL size digit_cnt and fail_cnt with $clog2 of their limits +1; timers SHALL saturate and never wrap.

Reset
REQ-031 SHALL on rst_i set the state to IDLE, all counters and timers to 0, and number_o=0, num_vld_o=0, state_o=00, open_o=0, alarm_o=0.
REQ-032 SHALL, on rst_i asserted mid-operation (including OPEN and LOCKOUT), drop all outputs to reset values immediately, without waiting for a clock edge.

Structure
REQ-033 SHALL take the state_o encodings and the key codes 0xA/0xB from shared package doorlock_pkg, also used by passcode.
REQ-034 SHALL build OPEN, inactivity and lockout timing from one sub-module, dl_timer: a loadable saturating down-counter with a done flag, instanced once and reloaded per state.

Verification (CODE_LEN=6, CHECK_LAT=2, OPEN_CYCLES=20, TIMEOUT_CYCLES=50, MAX_FAIL=3, LOCKOUT_CYCLES=40)
REQ-035 SHALL verify: digits 1,2,3,4,5,6 with corr_i=1 -> six num_vld_o pulses carrying 1..6, then open_o high for exactly 20 cycles, then state_o=00.
REQ-036 SHALL verify: three wrong six-digit codes (corr_i=0) -> alarm_o high for exactly 40 cycles, digits during lockout give no num_vld_o, and the next correct code opens.
REQ-037 SHALL verify: digits 7,7 then '*' -> state_o=00 on the following cycle, and a fresh six-digit entry starts digit_cnt at 1.
REQ-038 SHALL verify: one digit then 50 idle cycles -> state_o=00 exactly at timeout; a digit strobe on the timeout cycle produces no num_vld_o.
REQ-039 SHALL verify: '#' in OPEN -> state_o=10 and open_o=0; six digits forwarded, then state_o=00.
REQ-040 SHALL verify: rst_i pulsed during OPEN between clock edges -> open_o=0 before the next edge, and all outputs at reset values.

Source files
------------

// File: rtl/doorlock_pkg.sv
// doorlock_pkg
// Shared definitions for the door-lock controller and the passcode store:
// external lock-state encodings, special key codes, the internal FSM state
// type and small decode helpers.
package doorlock_pkg;

    // Lock state as seen by the passcode store on state_o
    localparam logic [1:0] ST_O_IDLE = 2'b00;
    localparam logic [1:0] ST_O_ENT  = 2'b01;
    localparam logic [1:0] ST_O_SET  = 2'b10;
    localparam logic [1:0] ST_O_OPEN = 2'b11;

    // Keypad codes; 0x0-0x9 are digits, 0xC-0xF are unused
    localparam logic [3:0] KEY_STAR = 4'hA;   // abort
    localparam logic [3:0] KEY_HASH = 4'hB;   // enter set-code mode

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENT_CODE,
        S_CHECK,
        S_OPEN,
        S_SET,
        S_LOCKOUT
    } lock_state_e;

    // CHECK looks like ENT_CODE and LOCKOUT looks like IDLE to the store
    function automatic logic [1:0] state_enc(input lock_state_e s);
        logic [1:0] enc;
        case (s)
            S_ENT_CODE, S_CHECK: enc = ST_O_ENT;
            S_OPEN:              enc = ST_O_OPEN;
            S_SET:               enc = ST_O_SET;
            default:             enc = ST_O_IDLE;
        endcase
        return enc;
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/dl_timer.sv
// dl_timer
// Loadable saturating down-counter. A load takes priority; otherwise the
// count decrements until it reaches zero and then holds there.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (count -> 0)
//   load_i       : load val_i this cycle
//   val_i        : load value; done_o rises val_i cycles after the load
//   done_o       : count is zero
module dl_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl
// Keypad door-lock controller. Forwards entered digits to the passcode store,
// waits for its match result, drives the unlock output, supports changing the
// code from the OPEN state, and locks out the keypad after repeated failures.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   key_i        : key code (0-9 digit, 0xA '*', 0xB '#')
//   key_vld_i    : one-cycle strobe qualifying key_i
//   corr_i       : code-match result from the passcode store
//   number_o     : forwarded digit
//   num_vld_o    : one-cycle pulse qualifying number_o
//   state_o      : lock state for the passcode store
//   open_o       : door unlock drive
//   alarm_o      : lockout indication
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int CODE_LEN       = 6,
    parameter int CHECK_LAT      = 2,
    parameter int OPEN_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 10000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] key_i,
    input  logic       key_vld_i,
    input  logic       corr_i,
    output logic [3:0] number_o,
    output logic       num_vld_o,
    output logic [1:0] state_o,
    output logic       open_o,
    output logic       alarm_o
);

    localparam int DW     = $clog2(CODE_LEN) + 1;
    localparam int FW     = $clog2(MAX_FAIL) + 1;
    localparam int TMAX_A = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
    localparam int TMAX_B = (TMAX_A > LOCKOUT_CYCLES) ? TMAX_A : LOCKOUT_CYCLES;
    localparam int TMAX   = (TMAX_B > CHECK_LAT) ? TMAX_B : CHECK_LAT;
    localparam int TW     = $clog2(TMAX) + 1;

    // Timer reload values: done is seen on the Nth cycle after entering a state
    localparam logic [TW-1:0] T_CHECK = TW'(CHECK_LAT - 1);
    localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] T_IDLE  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK  = TW'(LOCKOUT_CYCLES - 1);

    lock_state_e   state_q, state_d;
    logic [DW-1:0] digit_cnt_q, digit_cnt_d;
    logic [FW-1:0] fail_cnt_q, fail_cnt_d;
    logic [3:0]    number_q, number_d;
    logic          num_vld_q, num_vld_d;
    logic [1:0]    state_o_q, state_o_d;
    logic          open_q, open_d;
    logic          alarm_q, alarm_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    logic          key_dig, key_star, key_hash;

    assign key_dig  = key_vld_i && is_digit(key_i);
    assign key_star = key_vld_i && (key_i == KEY_STAR);
    assign key_hash = key_vld_i && (key_i == KEY_HASH);

    // One timer serves CHECK latency, OPEN hold, inactivity and lockout;
    // every state entry that needs timing reloads it.
    dl_timer #(
        .W (TW)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        number_d    = number_q;
        num_vld_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            S_IDLE: begin
                if (key_dig) begin
                    number_d    = key_i;
                    num_vld_d   = 1'b1;
                    digit_cnt_d = DW'(1);
                    tmr_load    = 1'b1;
                    if (CODE_LEN == 1) begin
                        state_d = S_CHECK;
                        tmr_val = T_CHECK;
                    end else begin
                        state_d = S_ENT_CODE;
                        tmr_val = T_IDLE;
                    end
                end
            end

            S_ENT_CODE: begin
                // Timeout outranks any key arriving on the same cycle
                if (tmr_done) begin
                    state_d     = S_IDLE;
                    digit_cnt_d = '0;
                end else if (key_star) begin
                    state_d     = S_IDLE;
                    digit_cnt_d = '0;
                end else if (key_dig) begin
                    number_d    = key_i;
                    num_vld_d   = 1'b1;
                    digit_cnt_d = digit_cnt_q + DW'(1);
                    tmr_load    = 1'b1;
                    if (digit_cnt_q == DW'(CODE_LEN - 1)) begin
                        state_d = S_CHECK;
                        tmr_val = T_CHECK;
                    end else begin
                        tmr_val = T_IDLE;
                    end
                end
            end

            S_CHECK: begin
                // corr_i is only trusted on the last CHECK cycle
                if (tmr_done) begin
                    digit_cnt_d = '0;
                    tmr_load    = 1'b1;
                    if (corr_i) begin
                        state_d    = S_OPEN;
                        fail_cnt_d = '0;
                        tmr_val    = T_OPEN;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FW'(1);
                        if (fail_cnt_q >= FW'(MAX_FAIL - 1)) begin
                            state_d = S_LOCKOUT;
                            tmr_val = T_LOCK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            S_OPEN: begin
                if (key_hash) begin
                    state_d     = S_SET;
                    digit_cnt_d = '0;
                    tmr_load    = 1'b1;
                    tmr_val     = T_IDLE;
                end else if (tmr_done) begin
                    state_d = S_IDLE;
                end
            end

            S_SET: begin
                // Full code already forwarded: leave one cycle after the last pulse
                if (digit_cnt_q == DW'(CODE_LEN)) begin
                    state_d     = S_IDLE;
                    digit_cnt_d = '0;
                end else if (tmr_done || key_star) begin
                    state_d     = S_IDLE;
                    digit_cnt_d = '0;
                end else if (key_dig) begin
                    number_d    = key_i;
                    num_vld_d   = 1'b1;
                    digit_cnt_d = digit_cnt_q + DW'(1);
                    tmr_load    = 1'b1;
                    tmr_val     = T_IDLE;
                end
            end

            S_LOCKOUT: begin
                if (tmr_done) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                digit_cnt_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        state_o_d = state_enc(state_d);
        open_d    = (state_d == S_OPEN);
        alarm_d   = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
            number_q    <= '0;
            num_vld_q   <= 1'b0;
            state_o_q   <= ST_O_IDLE;
            open_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            number_q    <= number_d;
            num_vld_q   <= num_vld_d;
            state_o_q   <= state_o_d;
            open_q      <= open_d;
            alarm_q     <= alarm_d;
        end
    end

    assign number_o  = number_q;
    assign num_vld_o = num_vld_q;
    assign state_o   = state_o_q;
    assign open_o    = open_q;
    assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb_doorlock_ctrl
// Directed bench for doorlock_ctrl. Each forwarded digit is queued as an
// expectation (digit plus state_o at the pulse) and a monitor pops and checks
// on every num_vld_o pulse; timing and state checks run inline.
module tb_doorlock_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] key_i;
    logic       key_vld_i;
    logic       corr_i;
    logic [3:0] number_o;
    logic       num_vld_o;
    logic [1:0] state_o;
    logic       open_o;
    logic       alarm_o;

    typedef struct {
        logic [3:0] d;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    doorlock_ctrl #(
        .CODE_LEN       (6),
        .CHECK_LAT      (2),
        .OPEN_CYCLES    (20),
        .TIMEOUT_CYCLES (50),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (40)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .key_i     (key_i),
        .key_vld_i (key_vld_i),
        .corr_i    (corr_i),
        .number_o  (number_o),
        .num_vld_o (num_vld_o),
        .state_o   (state_o),
        .open_o    (open_o),
        .alarm_o   (alarm_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_i     = k;
        key_vld_i = 1'b1;
        step();
        key_vld_i = 1'b0;
        key_i     = 4'hF;
    endtask

    // Digit that must be forwarded with the given state_o on its pulse
    task automatic dig(input logic [3:0] k, input logic [1:0] st);
        exp_t e;
        e.d  = k;
        e.st = st;
        q.push_back(e);
        press(k);
    endtask

    task automatic code16(input logic [1:0] st);
        for (int d = 1; d <= 6; d++) dig(4'(d), st);
    endtask

    function automatic logic pick(input bit alarm_sel);
        return alarm_sel ? alarm_o : open_o;
    endfunction

    // Wait (bounded) for the signal to rise, then count its high cycles
    task automatic meas(input bit alarm_sel, output int n);
        int w;
        w = 0;
        n = 0;
        while (!pick(alarm_sel) && w < 100) begin
            step();
            w++;
        end
        while (pick(alarm_sel) && n < 500) begin
            n++;
            step();
        end
    endtask

    task automatic drained(input string name);
        chk(name, q.size(), 0);
    endtask

    initial begin
        int n;

        rst_i     = 1'b1;
        key_i     = 4'h0;
        key_vld_i = 1'b0;
        corr_i    = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst_i && num_vld_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse_digit", int'(number_o), -1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("fwd_digit", int'(number_o), int'(e.d));
                        chk("fwd_state", int'(state_o), int'(e.st));
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_number", int'(number_o), 0);
        chk("rst_num_vld", int'(num_vld_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_open", int'(open_o), 0);
        chk("rst_alarm", int'(alarm_o), 0);
        rst_i = 1'b0;
        step();

        // Correct code opens for exactly 20 cycles
        corr_i = 1'b1;
        code16(2'b01);
        chk("check_state", int'(state_o), 1);
        meas(1'b0, n);
        chk("open_len", n, 20);
        chk("after_open_state", int'(state_o), 0);
        drained("a_drained");

        // Three wrong codes lead to a 40-cycle lockout
        corr_i = 1'b0;
        for (int r = 0; r < 3; r++) begin
            code16(2'b01);
            if (r < 2) begin
                step(); step(); step();
                chk("wrong_idle_state", int'(state_o), 0);
                chk("wrong_no_alarm", int'(alarm_o), 0);
            end
        end
        step(); step();
        chk("lock_alarm_start", int'(alarm_o), 1);
        chk("lock_state", int'(state_o), 0);
        n = int'(alarm_o);
        for (int i = 0; i < 60; i++) begin
            key_vld_i = (i < 5);
            key_i     = 4'd5;
            step();
            if (alarm_o) n++;
        end
        key_vld_i = 1'b0;
        chk("alarm_len", n, 40);
        chk("after_lock_state", int'(state_o), 0);
        corr_i = 1'b1;
        code16(2'b01);
        meas(1'b0, n);
        chk("open_after_lock", n, 20);
        drained("b_drained");

        // Abort with '*', then a fresh entry needs all six digits
        dig(4'd7, 2'b01);
        dig(4'd7, 2'b01);
        press(4'hA);
        chk("abort_state", int'(state_o), 0);
        code16(2'b01);
        meas(1'b0, n);
        chk("open_after_abort", n, 20);
        drained("c_drained");

        // Inactivity timeout; a digit on the timeout cycle is dropped
        dig(4'd3, 2'b01);
        chk("to_enter_state", int'(state_o), 1);
        repeat (49) step();
        chk("to_before_state", int'(state_o), 1);
        press(4'd8);
        chk("to_state", int'(state_o), 0);
        step();
        chk("to_no_pulse", int'(num_vld_o), 0);
        drained("d_drained");

        // '#' in OPEN enters SET, six digits forwarded, then IDLE
        code16(2'b01);
        meas(1'b0, n);  // let one OPEN window run out so the next one starts clean
        chk("open_pre_set", n, 20);
        code16(2'b01);
        step(); step();
        chk("open_for_set", int'(open_o), 1);
        press(4'hB);
        chk("set_state", int'(state_o), 2);
        chk("set_open", int'(open_o), 0);
        for (int d = 9; d >= 4; d--) dig(4'(d), 2'b10);
        chk("set_last_state", int'(state_o), 2);
        step();
        chk("set_exit_state", int'(state_o), 0);
        drained("e_drained");

        // Asynchronous reset mid-cycle during OPEN
        code16(2'b01);
        step(); step(); step();
        chk("open_before_rst", int'(open_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_open", int'(open_o), 0);
        chk("arst_state", int'(state_o), 0);
        chk("arst_number", int'(number_o), 0);
        chk("arst_num_vld", int'(num_vld_o), 0);
        chk("arst_alarm", int'(alarm_o), 0);
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_open", int'(open_o), 0);
        drained("f_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
